// File: rtl/fetch_unit.sv
// Instruction fetch/issue stage: owns the PC, fetches over req/ack, issues over
// valid/ready, and resolves SAL/SIG jumps and the ESP halt locally.
module fetch_unit #(
    parameter int          AW       = 16,
    parameter int          IW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [1:0]    id_op,
    output logic [1:0]    id_inst,
    output logic          id_imm,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc,
    input  logic          cond_flag,
    input  logic          resume,
    output logic          halted
);

    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALT} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt, w_pc_inc, w_target;
    logic          r_req, w_req_nxt, w_load;
    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_id_pc;
    logic [1:0]    w_op, w_inst;
    logic          w_is_sal, w_is_sig, w_is_esp;

    assign w_op     = r_instr[31:30];
    assign w_inst   = r_instr[29:28];
    assign w_target = AW'(r_instr[18:0]);
    assign w_pc_inc = r_pc + AW'(1);
    assign w_is_sal = (w_op == 2'b00) && (w_inst == 2'b00);
    assign w_is_sig = (w_op == 2'b00) && (w_inst == 2'b11);
    assign w_is_esp = (w_op == 2'b01) && (w_inst == 2'b00);

    // r_req is cleared by reset so the first request only appears after the
    // first clock edge; FETCH with r_req=0 exists only in that single cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_req;
        w_load      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!r_req) begin
                    w_req_nxt = 1'b1;
                end else if (imem_ack) begin
                    w_load      = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (id_ready) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_FETCH;
                    w_req_nxt   = 1'b1;
                    if (w_is_sal || (w_is_sig && cond_flag))
                        w_pc_nxt = w_target;
                    if (w_is_esp) begin
                        w_state_nxt = S_HALT;
                        w_req_nxt   = 1'b0;
                    end
                end
            end
            S_HALT: begin
                if (resume) begin
                    w_state_nxt = S_FETCH;
                    w_req_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_instr <= '0;
            r_id_pc <= '0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_req <= w_req_nxt;
            if (w_load) begin
                r_instr <= imem_rdata;
                r_id_pc <= r_pc;
            end
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign id_valid  = (r_state == S_ISSUE);
    assign id_op     = r_instr[31:30];
    assign id_inst   = r_instr[29:28];
    assign id_imm    = r_instr[27];
    assign id_instr  = r_instr;
    assign id_pc     = r_id_pc;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of instructions walked in program
// order, plus hand sequences for reset, halt/resume and mid-issue reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [1:0]  id_op;
    logic [1:0]  id_inst;
    logic        id_imm;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic        cond_flag;
    logic        resume;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.AW(16), .IW(32), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_op(id_op), .id_inst(id_inst), .id_imm(id_imm),
        .id_instr(id_instr), .id_pc(id_pc),
        .cond_flag(cond_flag), .resume(resume), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] word;
        logic [1:0]  op;
        logic [1:0]  inst;
        logic        imm;
        logic        cond;
        int          ack_dly;
        int          rdy_dly;
        logic        esp;
        logic [15:0] nxt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_issue(input string name, input vec_t v);
        chk({name, " valid"}, {63'd0, id_valid}, 64'd1);
        chk({name, " fields"}, {31'd0, id_op, id_inst, id_imm, id_instr},
            {31'd0, v.op, v.inst, v.imm, v.word});
        chk({name, " id_pc"}, {48'd0, id_pc}, {48'd0, v.pc});
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) chk({name, " req timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        // pc, word, op, inst, imm, cond, ack_dly, rdy_dly, esp, next
        tbl[0]  = '{16'h0000, 32'hC000_0000, 2'd3, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0001};
        tbl[1]  = '{16'h0001, 32'hD000_0000, 2'd3, 2'd1, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0002};
        tbl[2]  = '{16'h0002, 32'hF000_0000, 2'd3, 2'd3, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0003};
        tbl[3]  = '{16'h0003, 32'h4000_0000, 2'd1, 2'd0, 1'b0, 1'b0, 0, 0, 1'b1, 16'h0004};
        tbl[4]  = '{16'h0004, 32'h8800_0000, 2'd2, 2'd0, 1'b1, 1'b0, 3, 4, 1'b0, 16'h0005};
        tbl[5]  = '{16'h0005, 32'h0000_0040, 2'd0, 2'd0, 1'b0, 1'b1, 0, 0, 1'b0, 16'h0040};
        tbl[6]  = '{16'h0040, 32'h0000_0008, 2'd0, 2'd0, 1'b0, 1'b0, 1, 0, 1'b0, 16'h0008};
        tbl[7]  = '{16'h0008, 32'h3000_0010, 2'd0, 2'd3, 1'b0, 1'b1, 0, 0, 1'b0, 16'h0010};
        tbl[8]  = '{16'h0010, 32'h0000_0008, 2'd0, 2'd0, 1'b0, 1'b0, 0, 2, 1'b0, 16'h0008};
        tbl[9]  = '{16'h0008, 32'h3000_0010, 2'd0, 2'd3, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0009};
        tbl[10] = '{16'h0009, 32'h0000_FFFF, 2'd0, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 16'hFFFF};
        tbl[11] = '{16'hFFFF, 32'h9000_0000, 2'd2, 2'd1, 1'b0, 1'b1, 0, 0, 1'b0, 16'h0000};
        tbl[12] = '{16'h0000, 32'hC000_0000, 2'd3, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0001};
        // target bits above AW are dropped: 0x70123 -> 0x0123
        tbl[13] = '{16'h0001, 32'h0807_0123, 2'd0, 2'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'h0123};

        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        id_ready = 1'b1; cond_flag = 1'b0; resume = 1'b1;
        #23;
        chk("reset req", {63'd0, imem_req}, 64'd0);
        chk("reset addr", {48'd0, imem_addr}, 64'd0);
        chk("reset outs", {28'd0, id_valid, halted, id_op, id_inst, id_imm, id_instr},
            64'd0);
        chk("reset id_pc", {48'd0, id_pc}, 64'd0);
        imem_ack = 1'b0; id_ready = 1'b0; resume = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("req before first edge", {63'd0, imem_req}, 64'd0);
        @(negedge clk);
        chk("req after first edge", {47'd0, imem_req, imem_addr}, {47'd0, 1'b1, 16'h0000});

        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            wait_req(nm);
            chk({nm, " addr"}, {48'd0, imem_addr}, {48'd0, tbl[i].pc});
            resume = (i == 4);
            for (int k = 0; k < tbl[i].ack_dly; k++) begin
                imem_ack = 1'b0; imem_rdata = 32'h1234_5678;
                @(negedge clk);
                chk({nm, " wait req/addr"}, {47'd0, imem_req, imem_addr},
                    {47'd0, 1'b1, tbl[i].pc});
            end
            imem_ack = 1'b1; imem_rdata = tbl[i].word;
            @(negedge clk);
            imem_ack = 1'b0; imem_rdata = 32'hA5A5_A5A5;
            chk({nm, " req drop"}, {63'd0, imem_req}, 64'd0);
            chk_issue(nm, tbl[i]);
            for (int k = 0; k < tbl[i].rdy_dly; k++) begin
                id_ready = 1'b0; cond_flag = ~tbl[i].cond;
                @(negedge clk);
                chk_issue({nm, " stall"}, tbl[i]);
                chk({nm, " stall req"}, {63'd0, imem_req}, 64'd0);
            end
            resume = 1'b0;
            id_ready = 1'b1; cond_flag = tbl[i].cond;
            @(negedge clk);
            id_ready = 1'b0; cond_flag = ~tbl[i].cond;
            if (tbl[i].esp) begin
                for (int k = 0; k < 6; k++) begin
                    chk({nm, " halt"}, {61'd0, halted, imem_req, id_valid}, {61'd0, 3'b100});
                    @(negedge clk);
                end
                resume = 1'b1;
                @(negedge clk);
                resume = 1'b0;
            end
            chk({nm, " next"}, {46'd0, halted, imem_req, imem_addr},
                {46'd0, 1'b0, 1'b1, tbl[i].nxt});
        end

        // reset arrives while an instruction at 0x0123 is being issued
        imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pre-reset issue", {47'd0, id_valid, id_pc}, {47'd0, 1'b1, 16'h0123});
        #2 rst_n = 1'b0;
        #1;
        chk("async valid drop", {63'd0, id_valid}, 64'd0);
        chk("async outs", {15'd0, imem_req, id_instr, id_pc}, 64'd0);
        chk("async addr", {48'd0, imem_addr}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset fetch", {47'd0, imem_req, imem_addr}, {47'd0, 1'b1, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
